// File: rtl/uart_msg_pkg.sv
// Shared types and ASCII constants for the UART message print blocks.
package uart_msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFX1,
        DIG,
        CR,
        LF
    } msg_state_e;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_X  = 8'h78;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit value to ASCII hex digit, letter case selected by UPPERCASE.
module hex_nibble_to_ascii
    import uart_msg_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    localparam logic [7:0] ASC_A = UPPERCASE ? ASC_UA : ASC_LA;

    always_comb begin
        ascii = ASC_0;
        if (nibble < 4'd10) begin
            ascii = ASC_0 + 8'(nibble);
        end else begin
            ascii = ASC_A + 8'(nibble - 4'd10);
        end
    end

endmodule

// File: rtl/uart_hex_msg_tx.sv
// Converts a binary word into an ASCII hex line and writes it, one character
// per cycle, into the UART transmitter FIFO.
module uart_hex_msg_tx
    import uart_msg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          PREFIX_EN  = 1'b1,
    parameter bit          SEND_CRLF  = 1'b1,
    parameter bit          UPPERCASE  = 1'b1
) (
    input  logic                  clk_tx,
    input  logic                  rst_clk_tx_n,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [7:0]            tx_din,
    output logic                  write_en,
    input  logic                  tx_fifo_full,
    output logic                  busy
);

    localparam int unsigned NIB   = DATA_WIDTH / 4;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    msg_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              digit_ascii;

    hex_nibble_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_nibble (
        .nibble (data_q[DATA_WIDTH-1 -: 4]),
        .ascii  (digit_ascii)
    );

    // State, shift register and digit counter.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; every non-idle state advances only when its character is written.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    cnt_d   = CNT_W'(NIB - 1);
                    state_d = PREFIX_EN ? PFX0 : DIG;
                end
            end
            PFX0: if (!tx_fifo_full) state_d = PFX1;
            PFX1: if (!tx_fifo_full) state_d = DIG;
            DIG: begin
                if (!tx_fifo_full) begin
                    if (cnt_q != '0) begin
                        data_d = data_q << 4;
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = SEND_CRLF ? CR : IDLE;
                    end
                end
            end
            CR: if (!tx_fifo_full) state_d = LF;
            LF: if (!tx_fifo_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Character select depends on state only so it stays stable across a stall.
    always_comb begin
        tx_din = 8'h00;
        unique case (state_q)
            IDLE:    tx_din = 8'h00;
            PFX0:    tx_din = ASC_0;
            PFX1:    tx_din = ASC_X;
            DIG:     tx_din = digit_ascii;
            CR:      tx_din = ASC_CR;
            LF:      tx_din = ASC_LF;
            default: tx_din = 8'h00;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign req_ready = (state_q == IDLE);
    assign write_en  = busy && !tx_fifo_full;

endmodule

// File: tb/tb_uart_hex_msg_tx.sv
// Directed bench for uart_hex_msg_tx covering default, lowercase and narrow builds.
module tb_uart_hex_msg_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_data = '0;
    logic        req_valid = 1'b0;
    logic        full = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic       rdy_a, we_a, busy_a;
    logic [7:0] din_a;
    logic       rdy_b, we_b, busy_b;
    logic [7:0] din_b;
    logic       rdy_c, we_c, busy_c;
    logic [7:0] din_c;

    logic       obs_rdy, obs_we, obs_busy;
    logic [7:0] obs_din;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_hex_msg_tx u_dut_a (
        .clk_tx       (clk),
        .rst_clk_tx_n (rst_n),
        .req_data     (req_data),
        .req_valid    (req_valid && (sel == 2'd0)),
        .req_ready    (rdy_a),
        .tx_din       (din_a),
        .write_en     (we_a),
        .tx_fifo_full (full),
        .busy         (busy_a)
    );

    uart_hex_msg_tx #(.UPPERCASE(1'b0)) u_dut_b (
        .clk_tx       (clk),
        .rst_clk_tx_n (rst_n),
        .req_data     (req_data),
        .req_valid    (req_valid && (sel == 2'd1)),
        .req_ready    (rdy_b),
        .tx_din       (din_b),
        .write_en     (we_b),
        .tx_fifo_full (full),
        .busy         (busy_b)
    );

    uart_hex_msg_tx #(.DATA_WIDTH(8), .PREFIX_EN(1'b0), .SEND_CRLF(1'b0)) u_dut_c (
        .clk_tx       (clk),
        .rst_clk_tx_n (rst_n),
        .req_data     (req_data[7:0]),
        .req_valid    (req_valid && (sel == 2'd2)),
        .req_ready    (rdy_c),
        .tx_din       (din_c),
        .write_en     (we_c),
        .tx_fifo_full (full),
        .busy         (busy_c)
    );

    always_comb begin
        obs_rdy  = rdy_a;
        obs_we   = we_a;
        obs_busy = busy_a;
        obs_din  = din_a;
        if (sel == 2'd1) begin
            obs_rdy = rdy_b; obs_we = we_b; obs_busy = busy_b; obs_din = din_b;
        end else if (sel == 2'd2) begin
            obs_rdy = rdy_c; obs_we = we_c; obs_busy = busy_c; obs_din = din_c;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already set; checks then waits one cycle.
    task automatic step(input string tag, input logic exp_we, input logic [7:0] exp_din,
                        input logic exp_rdy, input logic exp_busy);
        #1;
        check({tag, ".we"},   8'(obs_we),   8'(exp_we));
        check({tag, ".din"},  obs_din,      exp_din);
        check({tag, ".rdy"},  8'(obs_rdy),  8'(exp_rdy));
        check({tag, ".busy"}, 8'(obs_busy), 8'(exp_busy));
        @(negedge clk);
    endtask

    task automatic run_msg(input string tag, input logic [7:0] msg [12]);
        for (int i = 0; i < 12; i++) begin
            step($sformatf("%s[%0d]", tag, i), 1'b1, msg[i], 1'b0, 1'b1);
        end
    endtask

    logic [7:0] msg_a [12];
    logic [7:0] msg_z [12];
    logic [7:0] msg_f [12];
    logic [7:0] msg_d [12];

    initial begin
        msg_a = '{8'h30, 8'h78, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        msg_z = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        msg_f = '{8'h30, 8'h78, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
        msg_d = '{8'h30, 8'h78, 8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A};

        // Reset state
        @(negedge clk);
        step("reset", 1'b0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b1;
        step("post_reset", 1'b0, 8'h00, 1'b1, 1'b0);

        // 1: default line, unstalled
        sel = 2'd0; req_data = 32'h1234ABCD; req_valid = 1'b1;
        step("t1.acc", 1'b0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        run_msg("t1", msg_a);
        step("t1.end", 1'b0, 8'h00, 1'b1, 1'b0);

        // 2: three-cycle stall while '3' is presented
        req_valid = 1'b1;
        step("t2.acc", 1'b0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("t2[%0d]", i), 1'b1, msg_a[i], 1'b0, 1'b1);
        full = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("t2.stall%0d", i), 1'b0, 8'h33, 1'b0, 1'b1);
        full = 1'b0;
        for (int i = 4; i < 12; i++) step($sformatf("t2[%0d]", i), 1'b1, msg_a[i], 1'b0, 1'b1);
        step("t2.end", 1'b0, 8'h00, 1'b1, 1'b0);

        // 3: back-to-back, req_valid held high; data changes while busy are ignored
        req_data = 32'h0; req_valid = 1'b1;
        step("t3.acc0", 1'b0, 8'h00, 1'b1, 1'b0);
        req_data = 32'hFFFFFFFF;
        run_msg("t3a", msg_z);
        step("t3.acc1", 1'b0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        run_msg("t3b", msg_f);
        step("t3.end", 1'b0, 8'h00, 1'b1, 1'b0);

        // 4: lowercase build
        sel = 2'd1; req_data = 32'hDEADBEEF; req_valid = 1'b1;
        step("t4.acc", 1'b0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        run_msg("t4", msg_d);
        step("t4.end", 1'b0, 8'h00, 1'b1, 1'b0);

        // 5: reset after five characters aborts the line
        sel = 2'd0; req_data = 32'h1234ABCD; req_valid = 1'b1;
        step("t5.acc", 1'b0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) step($sformatf("t5[%0d]", i), 1'b1, msg_a[i], 1'b0, 1'b1);
        rst_n = 1'b0;
        step("t5.rst", 1'b0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b1; req_valid = 1'b1;
        step("t5.reacc", 1'b0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        run_msg("t5r", msg_a);
        step("t5.end", 1'b0, 8'h00, 1'b1, 1'b0);

        // 6: 8-bit word, no prefix, no CR LF
        sel = 2'd2; req_data = 32'h000000A5; req_valid = 1'b1;
        step("t6.acc", 1'b0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        step("t6[0]", 1'b1, 8'h41, 1'b0, 1'b1);
        step("t6[1]", 1'b1, 8'h35, 1'b0, 1'b1);
        step("t6.end", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
